// File: rtl/barrier_field_if.sv
// Bus between the game objects (tank, shell, round control) and the barrier field.
//   master : drives tank geometry, shell position/flight flag and restore; receives barrier status
//   slave  : the barrier field itself
//   TankX/TankY/TankS  tank centre and half-size
//   shell_active, ShellX/ShellY  shell in flight and its point position
//   restore            new round, all barriers back to full health
//   barrier_collision  [0] +X blocked, [1] -X, [2] +Y, [3] -Y
//   barrier_alive      per-barrier presence
//   shell_hit          one-frame pulse when a shell is absorbed
//   hit_index          barrier that absorbed the latest shell
interface barrier_field_if #(
    parameter int unsigned NUM_BAR = 4
);
    logic [9:0]         TankX;
    logic [9:0]         TankY;
    logic [9:0]         TankS;
    logic               shell_active;
    logic [9:0]         ShellX;
    logic [9:0]         ShellY;
    logic               restore;
    logic [3:0]         barrier_collision;
    logic [NUM_BAR-1:0] barrier_alive;
    logic               shell_hit;
    logic [2:0]         hit_index;

    modport master (
        output TankX, TankY, TankS, shell_active, ShellX, ShellY, restore,
        input  barrier_collision, barrier_alive, shell_hit, hit_index
    );

    modport slave (
        input  TankX, TankY, TankS, shell_active, ShellX, ShellY, restore,
        output barrier_collision, barrier_alive, shell_hit, hit_index
    );
endinterface

// File: rtl/barrier_field.sv
// Destructible barrier field: per-frame tank contact flags and shell damage tracking.
//   frame_clk  frame-rate clock
//   Reset      asynchronous, active-high
//   bus        barrier_field_if.slave (tank/shell inputs, collision/alive/hit outputs)
// Barrier geometry is fixed by the packed BAR_* parameters, barrier i at bits [10i+9:10i].
module barrier_field #(
    parameter int unsigned               NUM_BAR     = 4,
    parameter int unsigned               BAR_HP      = 3,
    parameter int unsigned               COLL_MARGIN = 6,
    parameter logic [NUM_BAR*10-1:0]     BAR_X0      = {10'd520, 10'd500, 10'd10,  10'd300},
    parameter logic [NUM_BAR*10-1:0]     BAR_X1      = {10'd600, 10'd560, 10'd40,  10'd340},
    parameter logic [NUM_BAR*10-1:0]     BAR_Y0      = {10'd110, 10'd100, 10'd400, 10'd200},
    parameter logic [NUM_BAR*10-1:0]     BAR_Y1      = {10'd150, 10'd130, 10'd440, 10'd260}
) (
    input  logic            frame_clk,
    input  logic            Reset,
    barrier_field_if.slave  bus
);

    // 12 bits keeps edge+margin sums free of wrap for any 10-bit input
    localparam int unsigned CW  = 12;
    localparam int unsigned HPW = 3;

    typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} lock_t;

    lock_t              lock_state;
    lock_t              lock_nxt;
    logic               hit_fire_c;

    logic [HPW-1:0]     hp [NUM_BAR];
    logic [NUM_BAR-1:0] alive_q;
    logic [3:0]         coll_q;
    logic               shell_hit_q;
    logic [2:0]         hit_index_q;

    logic [3:0]         coll_c;
    logic               cand_valid_c;
    logic [2:0]         cand_idx_c;

    logic [CW-1:0]      tl, tr, tt, tb, bx0, bx1, by0, by1, marg;
    logic               yov, xov, c0, c1, c2, c3;

    // Tank bounding box (left/top saturate at 0) and per-barrier contact bands
    always_comb begin
        marg   = CW'(COLL_MARGIN);
        tl     = (bus.TankX >= bus.TankS) ? CW'(bus.TankX - bus.TankS) : '0;
        tr     = CW'(bus.TankX) + CW'(bus.TankS);
        tt     = (bus.TankY >= bus.TankS) ? CW'(bus.TankY - bus.TankS) : '0;
        tb     = CW'(bus.TankY) + CW'(bus.TankS);
        coll_c = '0;
        bx0 = '0; bx1 = '0; by0 = '0; by1 = '0;
        yov = 1'b0; xov = 1'b0; c0 = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        for (int i = 0; i < int'(NUM_BAR); i++) begin
            bx0 = CW'(BAR_X0[10*i +: 10]);
            bx1 = CW'(BAR_X1[10*i +: 10]);
            by0 = CW'(BAR_Y0[10*i +: 10]);
            by1 = CW'(BAR_Y1[10*i +: 10]);
            // strict overlap: touching a face without overlapping it does not block
            yov = (tb > by0) && (tt < by1);
            xov = (tr > bx0) && (tl < bx1);
            c0  = yov && (tr + marg >= bx0) && (tr <= bx0 + marg);
            c1  = yov && (tl <= bx1 + marg) && (tl + marg >= bx1);
            c2  = xov && (tb + marg >= by0) && (tb <= by0 + marg);
            c3  = xov && (tt <= by1 + marg) && (tt + marg >= by1);
            if (alive_q[i]) begin
                coll_c = coll_c | {c3, c2, c1, c0};
            end
        end
    end

    // Lowest-index alive barrier containing the shell point
    always_comb begin
        cand_valid_c = 1'b0;
        cand_idx_c   = '0;
        for (int i = int'(NUM_BAR) - 1; i >= 0; i--) begin
            if (alive_q[i] &&
                (bus.ShellX >= BAR_X0[10*i +: 10]) && (bus.ShellX <= BAR_X1[10*i +: 10]) &&
                (bus.ShellY >= BAR_Y0[10*i +: 10]) && (bus.ShellY <= BAR_Y1[10*i +: 10])) begin
                cand_valid_c = 1'b1;
                cand_idx_c   = 3'(i);
            end
        end
    end

    // Lock state register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lock_state <= ARMED;
        end else begin
            lock_state <= lock_nxt;
        end
    end

    // Lock next state: one hit per shell flight, re-armed once the shell is gone
    always_comb begin
        lock_nxt = lock_state;
        case (lock_state)
            ARMED:   if (bus.shell_active && cand_valid_c) lock_nxt = LOCKED;
            LOCKED:  if (!bus.shell_active)                lock_nxt = ARMED;
            default: lock_nxt = ARMED;
        endcase
        if (bus.restore) begin
            lock_nxt = ARMED;
        end
    end

    // Lock output decode: restore suppresses a same-edge hit
    always_comb begin
        hit_fire_c = 1'b0;
        if ((lock_state == ARMED) && bus.shell_active && cand_valid_c && !bus.restore) begin
            hit_fire_c = 1'b1;
        end
    end

    // Hit points, presence, and registered outputs
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            coll_q      <= '0;
            shell_hit_q <= 1'b0;
            hit_index_q <= '0;
            alive_q     <= '1;
            for (int i = 0; i < int'(NUM_BAR); i++) begin
                hp[i] <= HPW'(BAR_HP);
            end
        end else begin
            coll_q      <= coll_c;
            shell_hit_q <= hit_fire_c;
            if (hit_fire_c) begin
                hit_index_q <= cand_idx_c;
            end
            for (int i = 0; i < int'(NUM_BAR); i++) begin
                if (bus.restore) begin
                    hp[i]      <= HPW'(BAR_HP);
                    alive_q[i] <= 1'b1;
                end else if (hit_fire_c && (cand_idx_c == 3'(i))) begin
                    hp[i] <= hp[i] - HPW'(1);
                    if (hp[i] == HPW'(1)) begin
                        alive_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.barrier_collision = coll_q;
    assign bus.barrier_alive     = alive_q;
    assign bus.shell_hit         = shell_hit_q;
    assign bus.hit_index         = hit_index_q;

endmodule
